// File: rtl/axi_ram_rd_responder.sv
// AXI3 read-channel responder backed by a synchronous-read word RAM.
// A 2-deep AR queue feeds a burst FSM; beats return through a 2-deep R buffer.
module axi_ram_rd_responder #(
  parameter int unsigned RAM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot};

  // AR queue
  logic [3:0]  aq_id    [2];
  logic [31:0] aq_addr  [2];
  logic [7:0]  aq_len   [2];
  logic [2:0]  aq_size  [2];
  logic [1:0]  aq_burst [2];
  logic [1:0]  aq_err   [2];
  logic        aq_wp, aq_rp;
  logic [1:0]  aq_cnt;
  logic        aq_push, aq_pop;
  logic [1:0]  ar_err;

  assign arready = !reset && (aq_cnt != 2'd2);
  assign aq_push = arvalid && arready;

  always_comb begin
    ar_err = RespOkay;
    if ((araddr >> (RAM_AW + 2)) != 32'd0) begin
      ar_err = RespDecerr;
    end else if (arsize > 3'd2 || arburst[1]) begin
      ar_err = RespSlverr;
    end
  end

  always_ff @(posedge clk) begin
    if (aq_push) begin
      aq_id[aq_wp]    <= arid;
      aq_addr[aq_wp]  <= araddr;
      aq_len[aq_wp]   <= arlen;
      aq_size[aq_wp]  <= arsize;
      aq_burst[aq_wp] <= arburst;
      aq_err[aq_wp]   <= ar_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aq_wp  <= 1'b0;
      aq_rp  <= 1'b0;
      aq_cnt <= 2'd0;
    end else begin
      if (aq_push) aq_wp <= ~aq_wp;
      if (aq_pop)  aq_rp <= ~aq_rp;
      aq_cnt <= aq_cnt + {1'b0, aq_push} - {1'b0, aq_pop};
    end
  end

  // Burst FSM and current-burst registers
  state_e      state_q, state_d;
  logic [31:0] cur_addr_q;
  logic [7:0]  beats_left_q;
  logic [3:0]  cur_id_q;
  logic [2:0]  cur_size_q;
  logic [1:0]  cur_burst_q;
  logic [1:0]  cur_err_q;
  logic        issue, load, can_issue;

  logic        pipe_valid_q;
  logic [3:0]  pipe_id_q;
  logic [1:0]  pipe_resp_q;
  logic        pipe_last_q;

  logic [3:0]  ob_id   [2];
  logic [31:0] ob_data [2];
  logic [1:0]  ob_resp [2];
  logic        ob_last [2];
  logic        ob_wp, ob_rp;
  logic [1:0]  ob_cnt;
  logic        ob_push, ob_pop;

  // Buffered plus in-flight beats after this cycle's pop must leave a free slot.
  assign can_issue = ({1'b0, ob_cnt} + {2'b0, pipe_valid_q} - {2'b0, ob_pop}) < 3'd2;

  always_comb begin
    state_d = state_q;
    aq_pop  = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aq_cnt != 2'd0) begin
          aq_pop  = 1'b1;
          load    = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (can_issue) begin
          issue = 1'b1;
          if (beats_left_q == 8'd0) begin
            if (aq_cnt != 2'd0) begin
              aq_pop = 1'b1;
              load   = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cur_addr_q   <= 32'd0;
      beats_left_q <= 8'd0;
      cur_id_q     <= 4'd0;
      cur_size_q   <= 3'd0;
      cur_burst_q  <= 2'd0;
      cur_err_q    <= RespOkay;
    end else begin
      state_q <= state_d;
      if (load) begin
        cur_addr_q   <= aq_addr[aq_rp];
        beats_left_q <= aq_len[aq_rp];
        cur_id_q     <= aq_id[aq_rp];
        cur_size_q   <= aq_size[aq_rp];
        cur_burst_q  <= aq_burst[aq_rp];
        cur_err_q    <= aq_err[aq_rp];
      end else if (issue) begin
        beats_left_q <= beats_left_q - 8'd1;
        if (cur_burst_q == 2'b01) cur_addr_q <= cur_addr_q + (32'd1 << cur_size_q);
      end
    end
  end

  assign ram_en   = issue && (cur_err_q == RespOkay);
  assign ram_addr = issue ? cur_addr_q[RAM_AW+1:2] : '0;

  // Side pipeline aligns beat attributes with the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_id_q    <= 4'd0;
      pipe_resp_q  <= RespOkay;
      pipe_last_q  <= 1'b0;
    end else begin
      pipe_valid_q <= issue;
      if (issue) begin
        pipe_id_q   <= cur_id_q;
        pipe_resp_q <= cur_err_q;
        pipe_last_q <= (beats_left_q == 8'd0);
      end
    end
  end

  // Output buffer
  assign ob_push = pipe_valid_q;
  assign rvalid  = (ob_cnt != 2'd0);
  assign ob_pop  = rvalid && rready;

  always_ff @(posedge clk) begin
    if (ob_push) begin
      ob_id[ob_wp]   <= pipe_id_q;
      ob_data[ob_wp] <= (pipe_resp_q == RespOkay) ? ram_rdata : 32'h0;
      ob_resp[ob_wp] <= pipe_resp_q;
      ob_last[ob_wp] <= pipe_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ob_wp  <= 1'b0;
      ob_rp  <= 1'b0;
      ob_cnt <= 2'd0;
    end else begin
      if (ob_push) ob_wp <= ~ob_wp;
      if (ob_pop)  ob_rp <= ~ob_rp;
      ob_cnt <= ob_cnt + {1'b0, ob_push} - {1'b0, ob_pop};
    end
  end

  assign rid   = rvalid ? ob_id[ob_rp]   : 4'd0;
  assign rdata = rvalid ? ob_data[ob_rp] : 32'd0;
  assign rresp = rvalid ? ob_resp[ob_rp] : 2'd0;
  assign rlast = rvalid ? ob_last[ob_rp] : 1'b0;

endmodule

// File: tb/tb_axi_ram_rd_responder.sv
// Directed bench for axi_ram_rd_responder with a behavioural sync-read RAM.
module tb_axi_ram_rd_responder;

  logic        clk, reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        ram_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_rdata;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;
  beat_t beats[$];

  bit          bp_mon = 0;
  bit          noram = 0;
  int          issued, accepted;
  logic        prev_stall = 0;
  logic [38:0] prev_r;

  axi_ram_rd_responder #(.RAM_AW(16)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ram_rdata = 32'h0;
  always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat collector, stall-stability and RAM-enable monitors
  always @(negedge clk) begin
    beat_t b;
    if (rvalid && rready) begin
      b.id = rid; b.data = rdata; b.resp = rresp; b.last = rlast;
      beats.push_back(b);
    end
    if (prev_stall && !reset)
      check("stall_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, prev_r});
    prev_stall = rvalid && !rready && !reset;
    prev_r = {rid, rdata, rresp, rlast};
    if (noram) check("err_ram_en", ram_en, 0);
    if (bp_mon) begin
      if (ram_en) begin
        check("ram_en_occupancy", (issued - accepted - int'(rvalid && rready)) < 2, 1);
        issued++;
      end
      if (rvalid && rready) accepted++;
    end
  end

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_handshake", arready, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    wait_ar();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("beat_count", beats.size(), n);
  endtask

  task automatic check_reset_outputs(input logic exp_arready);
    check("rst_arready", arready, exp_arready);
    check("rst_rvalid", rvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rlast", rlast, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
  endtask

  initial begin
    logic [3:0] exp_id [10];
    int         exp_w  [10];
    int         gaps;
    int         k;

    reset = 1'b1; arvalid = 1'b0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    rready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = i;
    mem[5] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("arready_after_reset", arready, 1);
    @(posedge clk);
    #1;

    // Single read: latency and fields
    rready = 1'b1;
    send_ar(4'd3, 32'h14, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    check("t1_c1_rvalid", rvalid, 0);
    check("t1_c1_ram_en", ram_en, 0);
    @(negedge clk);
    check("t1_c2_ram_en", ram_en, 1);
    check("t1_c2_ram_addr", ram_addr, 5);
    check("t1_c2_rvalid", rvalid, 0);
    @(negedge clk);
    check("t1_c3_rvalid", rvalid, 0);
    @(negedge clk);
    check("t1_c4_rvalid", rvalid, 1);
    check("t1_rid", rid, 3);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_rresp", rresp, 0);
    check("t1_rlast", rlast, 1);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    // INCR burst under 1,0,0,1 back-pressure
    beats.delete();
    rready = 1'b0;
    issued = 0; accepted = 0; bp_mon = 1;
    send_ar(4'd2, 32'h0, 8'd3, 3'd2, 2'b01);
    k = 0;
    while (beats.size() < 4 && k < 80) begin
      rready = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk);
      #1;
      k++;
    end
    bp_mon = 0;
    check("t2_count", beats.size(), 4);
    for (int i = 0; i < 4; i++) if (i < beats.size()) begin
      check("t2_data", beats[i].data, i);
      check("t2_last", beats[i].last, i == 3);
      check("t2_id", beats[i].id, 2);
    end
    rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // FIXED burst then narrow INCR burst
    mem[0] = 32'hA0A0A0A0; mem[1] = 32'hB1B1B1B1; mem[2] = 32'hC2C2C2C2;
    beats.delete();
    send_ar(4'd4, 32'h8, 8'd2, 3'd2, 2'b00);
    send_ar(4'd5, 32'h0, 8'd4, 3'd0, 2'b01);
    wait_beats(8, 60);
    for (int i = 0; i < 8; i++) if (i < beats.size()) begin
      check("t3_data", beats[i].data,
            (i < 3) ? 32'hC2C2C2C2 : (i < 7) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      check("t3_last", beats[i].last, (i == 2) || (i == 7));
      check("t3_id", beats[i].id, (i < 3) ? 4 : 5);
    end
    repeat (3) @(posedge clk);
    #1;

    // Error bursts: DECERR out of range, SLVERR oversize
    beats.delete();
    noram = 1;
    send_ar(4'd6, 32'h0004_0000, 8'd1, 3'd2, 2'b01);
    send_ar(4'd7, 32'h10, 8'd0, 3'd3, 2'b01);
    wait_beats(3, 40);
    repeat (2) @(posedge clk);
    #1 noram = 0;
    for (int i = 0; i < 3; i++) if (i < beats.size()) begin
      check("t4_resp", beats[i].resp, (i < 2) ? 2'b11 : 2'b10);
      check("t4_data", beats[i].data, 0);
      check("t4_last", beats[i].last, i != 0);
      check("t4_id", beats[i].id, (i < 2) ? 6 : 7);
    end

    // Queue full refusal, then back-to-back drain
    beats.delete();
    rready = 1'b0;
    send_ar(4'd1, 32'h0, 8'd3, 3'd2, 2'b01);
    send_ar(4'd2, 32'h4, 8'd1, 3'd2, 2'b01);
    send_ar(4'd3, 32'h8, 8'd1, 3'd2, 2'b01);
    arid = 4'd4; araddr = 32'hC; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ar_refused", arready, 0);
      @(posedge clk);
      #1;
    end
    rready = 1'b1;
    wait_ar();
    gaps = 0;
    k = 0;
    while (beats.size() < 10 && k < 60) begin
      @(negedge clk);
      #1;
      if (!rvalid && beats.size() < 10) gaps++;
      k++;
    end
    check("t5_count", beats.size(), 10);
    check("t5_gaps", gaps, 0);
    exp_id = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
    exp_w  = '{0, 1, 2, 3, 1, 2, 2, 3, 3, 4};
    for (int i = 0; i < 10; i++) if (i < beats.size()) begin
      check("t5_id", beats[i].id, exp_id[i]);
      check("t5_data", beats[i].data, mem[exp_w[i]]);
      check("t5_last", beats[i].last, (i == 3) || (i == 5) || (i == 7) || (i == 9));
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a long burst
    beats.delete();
    send_ar(4'd8, 32'h0, 8'd7, 3'd2, 2'b01);
    k = 0;
    while (beats.size() < 2 && k < 30) begin
      @(posedge clk);
      k++;
    end
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    beats.delete();
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_stale", beats.size(), 0);
    send_ar(4'd9, 32'h14, 8'd0, 3'd2, 2'b01);
    wait_beats(1, 20);
    if (beats.size() > 0) begin
      check("t6_id", beats[0].id, 9);
      check("t6_data", beats[0].data, 32'hDEADBEEF);
      check("t6_resp", beats[0].resp, 0);
      check("t6_last", beats[0].last, 1);
    end
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
